// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one-entry skid buffer and redirect
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   stall             IF/ID is holding; fetch must not advance
//   branch_taken      redirect request (wins over stall)
//   branch_target     redirect byte address (low two bits ignored)
//   imem_en/addr      instruction-memory read request (addr is always pc_q)
//   imem_rdata        read data, valid one cycle after an enabled read
//   Instruction       instruction presented to IF/ID
//   PC_Out            byte address of Instruction
//   fetch_valid       Instruction/PC_Out carry a real instruction
//   fetch_count       instructions accepted by IF/ID (wraps)
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [63:0]        branch_target,
  output logic               imem_en,
  output logic [63:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Instruction,
  output logic [63:0]        PC_Out,
  output logic               fetch_valid,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {EMPTY, STREAM, HOLD} state_t;

  logic [63:0] pc_q;
  logic        inflight_valid;
  logic [63:0] inflight_pc;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [63:0] hold_pc;
  state_t      state;

  // Redirect targets are word aligned; the dropped bits are intentionally unused.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign imem_en   = ~stall & ~branch_taken & ~reset;
  assign imem_addr = pc_q;

  // The state is a view of the flags; inflight and hold are never both set
  // because a hold is only captured on a cycle that issues no read.
  always_comb begin
    if (hold_valid)          state = HOLD;
    else if (inflight_valid) state = STREAM;
    else                     state = EMPTY;
  end

  always_comb begin
    Instruction = 32'h0;
    PC_Out      = 64'h0;
    fetch_valid = 1'b0;
    if (branch_taken) begin
      // Whatever is in flight belongs to the wrong path.
      Instruction = 32'h0;
      PC_Out      = 64'h0;
      fetch_valid = 1'b0;
    end else if (hold_valid) begin
      Instruction = hold_instr;
      PC_Out      = hold_pc;
      fetch_valid = 1'b1;
    end else if (inflight_valid) begin
      Instruction = imem_rdata;
      PC_Out      = inflight_pc;
      fetch_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= 64'h0;
      hold_valid     <= 1'b0;
      hold_instr     <= 32'h0;
      hold_pc        <= 64'h0;
      fetch_count    <= '0;
    end else begin
      if (branch_taken) begin
        pc_q           <= {branch_target[63:2], 2'b00};
        inflight_valid <= 1'b0;
        hold_valid     <= 1'b0;
      end else begin
        inflight_valid <= imem_en;
        if (imem_en) begin
          pc_q        <= pc_q + 64'd4;
          inflight_pc <= pc_q;
        end
        case (state)
          STREAM: begin
            // Memory data is only valid this cycle; park it while IF/ID holds.
            if (stall) begin
              hold_valid <= 1'b1;
              hold_instr <= imem_rdata;
              hold_pc    <= inflight_pc;
            end
          end
          HOLD: begin
            // Hold is consumed now and pc_q is read in parallel, so no bubble.
            if (!stall) hold_valid <= 1'b0;
          end
          default: ;
        endcase
      end
      if (fetch_valid && !stall) fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam logic [63:0] W_RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;

  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic        fetch_valid;
  logic [31:0] fetch_count;

  logic        w_imem_en;
  logic [63:0] w_imem_addr;
  logic [31:0] w_imem_rdata = 32'h0;
  logic [31:0] w_Instruction;
  logic [63:0] w_PC_Out;
  logic        w_fetch_valid;
  logic [3:0]  w_fetch_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: is an instruction ready to present, which PC comes next,
  // and how many have been accepted.
  logic        m_avail;
  logic [63:0] m_pc;
  int unsigned m_count;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .Instruction(Instruction), .PC_Out(PC_Out),
    .fetch_valid(fetch_valid), .fetch_count(fetch_count)
  );

  instr_fetch #(.RESET_PC(W_RESET_PC), .COUNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .Instruction(w_Instruction), .PC_Out(w_PC_Out),
    .fetch_valid(w_fetch_valid), .fetch_count(w_fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = 64'h100 + (a >> 2);
    return w[31:0];
  endfunction

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mem_word(imem_addr);
    if (w_imem_en) w_imem_rdata <= mem_word(w_imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    tick();
    tick();
    reset = 1'b0;
    m_avail = 1'b0; m_pc = 64'h0; m_count = 0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [63:0] t);
    logic v;
    v = !b && m_avail;
    if (b) begin
      m_avail = 1'b0;
      m_pc    = {t[63:2], 2'b00};
    end else begin
      if (v && !s) begin
        m_pc    = m_pc + 64'd4;
        m_count = m_count + 1;
      end
      m_avail = !s || m_avail;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0;
    tick();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || PC_Out !== 64'h0 || Instruction !== 32'h0 ||
        imem_en !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 64'h0) begin
      mismatched++;
      $display("FAIL reset_state: valid=%b pc=%h ins=%h en=%b cnt=%0d addr=%h, required 0/0/0/0/0/0",
               fetch_valid, PC_Out, Instruction, imem_en, fetch_count, imem_addr);
    end
    compared++;
    if (w_imem_addr !== W_RESET_PC || w_fetch_valid !== 1'b0 || w_fetch_count !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_pc_param: addr=%h valid=%b cnt=%0d, required %h/0/0",
               w_imem_addr, w_fetch_valid, w_fetch_count, W_RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 64'h0) begin
      mismatched++;
      $display("FAIL stream_first_issue: valid=%b en=%b addr=%h, required 0/1/0",
               fetch_valid, imem_en, imem_addr);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (fetch_valid !== 1'b1 || PC_Out !== 64'(4 * i) || Instruction !== 32'(32'h100 + i)) begin
        mismatched++;
        $display("FAIL stream_deliver%0d: valid=%b pc=%h ins=%h, required 1/%h/%h",
                 i, fetch_valid, PC_Out, Instruction, 4 * i, 32'h100 + i);
      end
      tick();
    end
    @(negedge clk);
    compared++;
    if (fetch_count !== 32'd3) begin
      mismatched++;
      $display("FAIL stream_count: got %0d, required 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (fetch_valid !== 1'b1 || PC_Out !== 64'h8 || Instruction !== 32'h102 ||
          imem_en !== 1'b0 || fetch_count !== 32'd2) begin
        mismatched++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h ins=%h en=%b cnt=%0d, required 1/8/102/0/2",
                 i, fetch_valid, PC_Out, Instruction, imem_en, fetch_count);
      end
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'h8 || Instruction !== 32'h102 || imem_en !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: valid=%b pc=%h ins=%h en=%b, required 1/8/102/1",
               fetch_valid, PC_Out, Instruction, imem_en);
    end
    tick();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'hC || Instruction !== 32'h103 || fetch_count !== 32'd3) begin
      mismatched++;
      $display("FAIL stall_after: valid=%b pc=%h ins=%h cnt=%0d, required 1/c/103/3",
               fetch_valid, PC_Out, Instruction, fetch_count);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick(); tick();
    branch_taken = 1'b1; branch_target = 64'h40;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b0 || PC_Out !== 64'h0 || Instruction !== 32'h0) begin
      mismatched++;
      $display("FAIL branch_R: valid=%b en=%b pc=%h ins=%h, required 0/0/0/0",
               fetch_valid, imem_en, PC_Out, Instruction);
    end
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 64'h40) begin
      mismatched++;
      $display("FAIL branch_R1: valid=%b en=%b addr=%h, required 0/1/40",
               fetch_valid, imem_en, imem_addr);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (fetch_valid !== 1'b1 || PC_Out !== 64'(64'h40 + 4 * i) || Instruction !== 32'(32'h110 + i)) begin
        mismatched++;
        $display("FAIL branch_R%0d: valid=%b pc=%h ins=%h, required 1/%h/%h",
                 i + 2, fetch_valid, PC_Out, Instruction, 64'h40 + 4 * i, 32'h110 + i);
      end
      tick();
    end
  endtask

  task automatic test_branch_hold();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'h4 || Instruction !== 32'h101) begin
      mismatched++;
      $display("FAIL bhold_in_hold: valid=%b pc=%h ins=%h, required 1/4/101",
               fetch_valid, PC_Out, Instruction);
    end
    tick();
    branch_taken = 1'b1; branch_target = 64'h83;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b0) begin
      mismatched++;
      $display("FAIL bhold_R: valid=%b en=%b, required 0/0", fetch_valid, imem_en);
    end
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_addr !== 64'h80) begin
      mismatched++;
      $display("FAIL bhold_R1: valid=%b addr=%h, required 0/80", fetch_valid, imem_addr);
    end
    tick();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'h80 || Instruction !== 32'h120) begin
      mismatched++;
      $display("FAIL bhold_R2: valid=%b pc=%h ins=%h, required 1/80/120",
               fetch_valid, PC_Out, Instruction);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); tick(); tick();
    branch_taken = 1'b1; branch_target = 64'h200;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_first: valid=%b en=%b, required 0/0", fetch_valid, imem_en);
    end
    tick();
    branch_target = 64'h300;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_en !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_second: valid=%b en=%b, required 0/0", fetch_valid, imem_en);
    end
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b0 || imem_addr !== 64'h300 || imem_en !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_issue: valid=%b addr=%h en=%b, required 0/300/1",
               fetch_valid, imem_addr, imem_en);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (fetch_valid !== 1'b1 || PC_Out !== 64'(64'h300 + 4 * i) || Instruction !== 32'(32'h1C0 + i)) begin
        mismatched++;
        $display("FAIL b2b_deliver%0d: valid=%b pc=%h ins=%h, required 1/%h/%h",
                 i, fetch_valid, PC_Out, Instruction, 64'h300 + 4 * i, 32'h1C0 + i);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    #2;
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'h4) begin
      mismatched++;
      $display("FAIL rmid_pre: valid=%b pc=%h, required 1/4", fetch_valid, PC_Out);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (fetch_valid !== 1'b0 || PC_Out !== 64'h0 || Instruction !== 32'h0 ||
        fetch_count !== 32'h0 || imem_en !== 1'b0 || imem_addr !== 64'h0) begin
      mismatched++;
      $display("FAIL rmid_async: valid=%b pc=%h ins=%h cnt=%0d en=%b addr=%h, required all 0",
               fetch_valid, PC_Out, Instruction, fetch_count, imem_en, imem_addr);
    end
    stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    compared++;
    if (fetch_valid !== 1'b1 || PC_Out !== 64'h0 || Instruction !== 32'h100) begin
      mismatched++;
      $display("FAIL rmid_restart: valid=%b pc=%h ins=%h, required 1/0/100",
               fetch_valid, PC_Out, Instruction);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        exp_pc = W_RESET_PC + 64'(4 * (k - 1));
        compared++;
        if (w_fetch_valid !== 1'b1 || w_PC_Out !== exp_pc || w_Instruction !== mem_word(exp_pc)) begin
          mismatched++;
          $display("FAIL wrap_deliver%0d: valid=%b pc=%h ins=%h, required 1/%h/%h",
                   k, w_fetch_valid, w_PC_Out, w_Instruction, exp_pc, mem_word(exp_pc));
        end
      end
      tick();
    end
    @(negedge clk);
    compared++;
    if (w_fetch_count !== 4'd4) begin
      mismatched++;
      $display("FAIL wrap_count: got %0d, required 4", w_fetch_count);
    end
  endtask

  task automatic test_random();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stall         = ($urandom_range(0, 99) < 35);
      branch_taken  = ($urandom_range(0, 99) < 7);
      branch_target = 64'($urandom_range(0, 4095));
      @(negedge clk);
      exp_v = !branch_taken && m_avail;
      compared++;
      if (fetch_valid !== exp_v || imem_en !== (!stall && !branch_taken) || fetch_count !== m_count) begin
        mismatched++;
        $display("FAIL rand_ctl c%0d: valid=%b en=%b cnt=%0d, required %b/%b/%0d",
                 c, fetch_valid, imem_en, fetch_count, exp_v, !stall && !branch_taken, m_count);
      end
      compared++;
      if (exp_v) begin
        if (PC_Out !== m_pc || Instruction !== mem_word(m_pc)) begin
          mismatched++;
          $display("FAIL rand_data c%0d: pc=%h ins=%h, required %h/%h",
                   c, PC_Out, Instruction, m_pc, mem_word(m_pc));
        end
      end else if (PC_Out !== 64'h0 || Instruction !== 32'h0) begin
        mismatched++;
        $display("FAIL rand_idle c%0d: pc=%h ins=%h, required 0/0", c, PC_Out, Instruction);
      end
      model_step(stall, branch_taken, branch_target);
      tick();
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_hold();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Parameter COUNT_W, default 32, width of delivered-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  downstream IF/ID register holding; fetch shall not advance.
REQ-006 branch_taken  input  1  redirect request from later stage.
REQ-007 branch_target  input  64  redirect byte address.
REQ-008 imem_en  output  1  instruction-memory read enable.
REQ-009 imem_addr  output  64  instruction-memory read byte address (= pc_q).
REQ-010 imem_rdata  input  32  memory read data, valid exactly 1 cycle after an enabled read.
REQ-011 Instruction  output  32  instruction presented to IF/ID.
REQ-012 PC_Out  output  64  byte address of Instruction.
REQ-013 fetch_valid  output  1  Instruction/PC_Out carry a real instruction.
REQ-014 fetch_count  output  COUNT_W  count of instructions delivered to IF/ID.

Function
REQ-015 Internal state: pc_q (next address to issue), inflight_valid/inflight_pc (read returning this cycle), hold_valid/hold_instr/hold_pc (skid entry).
REQ-016 State machine, derived from flags: EMPTY (no inflight, no hold), STREAM (inflight_valid), HOLD (hold_valid).
REQ-017 imem_en = ~stall & ~branch_taken & ~reset; imem_addr = pc_q always.
REQ-018 On edge with imem_en: pc_q <= pc_q + 4 (wraps modulo 2^64), inflight_valid <= 1, inflight_pc <= pc_q.
REQ-019 On edge without imem_en: inflight_valid <= 0; pc_q unchanged unless redirect.
REQ-020 Output select, in priority: branch_taken -> Instruction=0, PC_Out=0, fetch_valid=0; hold_valid -> hold_instr/hold_pc, valid=1; inflight_valid -> imem_rdata/inflight_pc, valid=1; else 0/0/0.
REQ-021 STREAM + stall (no redirect): capture imem_rdata, inflight_pc into hold; hold_valid <= 1; go HOLD.
REQ-022 HOLD + stall: hold contents unchanged, no read issued, any number of cycles.
REQ-023 HOLD + ~stall: hold presented this cycle and consumed at edge; hold_valid <= 0; read of pc_q issued same cycle, so next cycle delivers pc_q with no bubble.
REQ-024 EMPTY + stall: nothing issued or captured; remain EMPTY.
REQ-025 Redirect (branch_taken) has priority over stall: pc_q <= {branch_target[63:2],2'b00}; inflight_valid <= 0; hold_valid <= 0; go EMPTY.
REQ-026 Redirect penalty: target issued cycle R+1, target delivered (fetch_valid=1) cycle R+2; fetch_valid=0 in cycles R and R+1.
REQ-027 Back-to-back redirects: last one wins; each cycle of branch_taken issues nothing.
REQ-028 fetch_count increments by 1 on each edge where fetch_valid & ~stall (delivery accepted); wraps at 2^COUNT_W.
REQ-029 No instruction shall be dropped or duplicated across any stall pattern absent redirect; delivered PCs strictly sequential by +4.

Reset
REQ-030 While reset=1: pc_q=RESET_PC, inflight_valid=0, hold_valid=0, fetch_count=0, Instruction=0, PC_Out=0, fetch_valid=0, imem_en=0.
REQ-031 Reset mid-operation (any state) discards inflight and hold immediately, asynchronously.
REQ-032 First edge after reset release with stall=0 issues RESET_PC; next cycle delivers it with fetch_valid=1.

Verification
REQ-033 Reset release, stall=0, memory word at n = 0x100+n/4: cycles 1,2,3 deliver (PC,Instr) = (0,0x100),(4,0x101),(8,0x102); fetch_count=3 after cycle 3.
REQ-034 Stall 3 cycles while STREAM at PC 8: outputs hold (8,0x102) valid for all 3 cycles plus release cycle; next cycle (12,0x103); fetch_count +1 only.
REQ-035 branch_taken with target 0x40 in cycle R while streaming: fetch_valid=0 in R and R+1; R+2 delivers PC 0x40; R+3 delivers 0x44.
REQ-036 branch_taken and stall together with hold_valid=1, target 0x83: hold discarded, pc_q=0x80, first delivery PC 0x80.
REQ-037 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8: deliveries ...FFF8, ...FFFC, then 0x0.
REQ-038 reset asserted in HOLD mid-cycle: outputs zero immediately; after release delivery restarts at RESET_PC.
